// File: rtl/tpu_host_seq_if.sv
// -----------------------------------------------------------------------------
// tpu_host_seq_if
//   Memory-mapped bus between the host-side sequencer and the TPU slave.
//   The TPU read data is combinational: it is valid in the same cycle as the
//   read address.
//
//   Signals:
//     r_w    1 = write, 0 = read (also 0 on every idle cycle)
//     addr   TPU byte address
//     wdata  write data to TPU dataIn
//     rdata  TPU dataOut
//
//   Modports:
//     master  sequencer side (drives r_w/addr/wdata, samples rdata)
//     slave   TPU side
// -----------------------------------------------------------------------------
interface tpu_host_seq_if #(
    parameter int DATAW = 64,
    parameter int ADDRW = 16
);
    logic             r_w;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] wdata;
    logic [DATAW-1:0] rdata;

    modport master (output r_w, output addr, output wdata, input rdata);
    modport slave  (input r_w, input addr, input wdata, output rdata);
endinterface

// File: rtl/tpu_host_seq.sv
// -----------------------------------------------------------------------------
// tpu_host_seq
//   Host-side bus initiator for the TPU. A job loads DIM A rows, DIM B rows
//   and 2*DIM C half-rows (from the operand stream, or zeros when zero_c was
//   set with start), issues the MatMul command, idles WAIT_CYCLES cycles for
//   the array to drain, then reads all 2*DIM C words out on the result stream.
//
//   WAIT_CYCLES must be at least 3*DIM-2 so the array has settled before the
//   first C read.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start, zero_c       job start pulse (ignored while busy); zero_c sampled
//                         with start selects zero-fill of C
//     in_valid/in_ready/in_data     operand stream (64-bit words)
//     out_valid/out_ready/out_data  result stream (four packed 16-bit C values)
//     bus                 TPU bus (master modport)
//     busy                high from the cycle after an accepted start until DONE
//     done                one-cycle pulse at job end
// -----------------------------------------------------------------------------
module tpu_host_seq #(
    parameter int DIM         = 8,
    parameter int DATAW       = 64,
    parameter int ADDRW       = 16,
    parameter int WAIT_CYCLES = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               zero_c,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATAW-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATAW-1:0]   out_data,
    tpu_host_seq_if.master     bus,
    output logic               busy,
    output logic               done
);

    localparam int IDXW = $clog2(2 * DIM) + 1;
    localparam int WCW  = $clog2(WAIT_CYCLES + 1);

    localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] B_BASE  = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'(16'h0400);

    localparam logic [IDXW-1:0] LAST_AB   = IDXW'(DIM - 1);
    localparam logic [IDXW-1:0] LAST_C    = IDXW'(2 * DIM - 1);
    localparam logic [WCW-1:0]  LAST_WAIT = WCW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, LOAD_C, MATMUL, WAIT, READ_C, DONE
    } state_t;

    state_t           state, state_next;
    logic [IDXW-1:0]  idx;       // row/word counter, cleared on every state entry
    logic             zc;        // zero-fill C for the current job
    logic [WCW-1:0]   wait_cnt;
    logic             step;      // one word transferred this cycle

    // Words are 8 bytes apart. For C this equals base + 16*row + 8*half, so
    // the low half of a row (even idx) is always written before its high half.
    function automatic logic [ADDRW-1:0] word_addr(logic [ADDRW-1:0] base,
                                                   logic [IDXW-1:0]  i);
        return base + ADDRW'({i, 3'b000});
    endfunction

    // State register and job datapath
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            zc       <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start)
                zc <= zero_c;
            if (state_next != state)
                idx <= '0;
            else if (step)
                idx <= idx + 1'b1;
            if (state_next != state)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD_A;
            LOAD_A:  if (step && idx == LAST_AB) state_next = LOAD_B;
            LOAD_B:  if (step && idx == LAST_AB) state_next = LOAD_C;
            LOAD_C:  if (step && idx == LAST_C) state_next = MATMUL;
            MATMUL:  state_next = WAIT;
            WAIT:    if (wait_cnt == LAST_WAIT) state_next = READ_C;
            READ_C:  if (step && idx == LAST_C) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    // NOTE: every output gets a default first; a path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        step      = 1'b0;
        bus.r_w   = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        case (state)
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                step     = in_valid;
                if (in_valid) begin
                    bus.r_w   = 1'b1;
                    bus.addr  = word_addr((state == LOAD_A) ? A_BASE : B_BASE, idx);
                    bus.wdata = in_data;
                end
            end
            LOAD_C: begin
                // Zero-fill writes one word per cycle and leaves the stream alone.
                in_ready = !zc;
                step     = zc || in_valid;
                if (step) begin
                    bus.r_w   = 1'b1;
                    bus.addr  = word_addr(C_BASE, idx);
                    bus.wdata = zc ? '0 : in_data;
                end
            end
            MATMUL: begin
                bus.r_w  = 1'b1;
                bus.addr = MM_ADDR;
            end
            READ_C: begin
                // Address holds while out_ready is low, so out_data holds too.
                out_valid = 1'b1;
                out_data  = bus.rdata;
                bus.addr  = word_addr(C_BASE, idx);
                step      = out_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tpu_host_seq.sv
// -----------------------------------------------------------------------------
// tb_tpu_host_seq
//   Randomized bench for tpu_host_seq. A job-level model turns the offered
//   operand words into the list of bus writes and C reads a job must produce;
//   one per-cycle compare step checks the bus, streams, busy and done against
//   it. A combinational TPU read model answers C reads.
// -----------------------------------------------------------------------------
module tb_tpu_host_seq;

    localparam int DIM         = 8;
    localparam int DATAW       = 64;
    localparam int ADDRW       = 16;
    localparam int WAIT_CYCLES = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, zero_c, in_valid, in_ready;
    logic             out_valid, out_ready, busy, done;
    logic [DATAW-1:0] in_data, out_data;
    logic [31:0]      salt;

    tpu_host_seq_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

    tpu_host_seq #(
        .DIM(DIM), .DATAW(DATAW), .ADDRW(ADDRW), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .zero_c(zero_c),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bus(bus), .busy(busy), .done(done)
    );

    // TPU read model: data is a function of the address and a per-job salt.
    function automatic logic [63:0] tpu_rd(logic [31:0] s, logic [15:0] a);
        return {s ^ {16'h0, a}, 16'hc0de ^ a, a};
    endfunction

    assign bus.rdata = bus.r_w ? 64'h0 : tpu_rd(salt, bus.addr);

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
        logic        from_stream;
    } wr_t;

    wr_t         exp_w[$];
    logic [15:0] exp_r[$];
    wr_t         obs_w[$];
    logic [63:0] words[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, wptr = 0, vmode = 0, rmode = 0, stall_left = 0;
    int mm_cycle = 0, last_lat = 0, done_cnt = 0;
    bit phase = 0, job_zc = 0, stray = 0, start_req = 0, tog = 0, first_rd = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name, string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic wr_t mk_wr(logic [15:0] a, logic [63:0] d, logic s);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.from_stream = s;
        return w;
    endfunction

    // Job model: every transfer the job must make, in order.
    function automatic void build_model(bit zc);
        exp_w.delete();
        exp_r.delete();
        for (int i = 0; i < DIM; i++)
            exp_w.push_back(mk_wr(16'h0100 + 16'(8 * i), words[i], 1'b1));
        for (int i = 0; i < DIM; i++)
            exp_w.push_back(mk_wr(16'h0200 + 16'(8 * i), words[DIM + i], 1'b1));
        for (int i = 0; i < 2 * DIM; i++)
            exp_w.push_back(zc ? mk_wr(16'h0300 + 16'(8 * i), 64'h0, 1'b0)
                               : mk_wr(16'h0300 + 16'(8 * i), words[2 * DIM + i], 1'b1));
        exp_w.push_back(mk_wr(16'h0400, 64'h0, 1'b0));
        for (int i = 0; i < 2 * DIM; i++)
            exp_r.push_back(16'h0300 + 16'(16 * (i / 2)) + 16'(8 * (i % 2)));
    endfunction

    // One clock cycle: drive inputs on the falling edge, then compare.
    task automatic tick();
        bit  fire, accept;
        wr_t w;
        @(negedge clk);
        cyc++;
        zero_c    = start_req ? job_zc : 1'($urandom_range(0, 1));
        start     = start_req | (stray & ($urandom_range(0, 5) == 0));
        start_req = 0;
        case (vmode)
            0:       in_valid = 1'b1;
            1:       begin tog = ~tog; in_valid = tog; end
            default: in_valid = 1'($urandom_range(0, 1));
        endcase
        if (wptr >= words.size()) in_valid = 1'b0;
        in_data = in_valid ? words[wptr] : {$urandom, $urandom};
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = !(exp_r.size() == 2 * DIM - 3 && stall_left > 0);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        fire   = in_valid && in_ready;
        accept = start && !phase;
        if (bus.r_w) begin
            if (exp_w.size() == 0) begin
                fail("spurious_write", $sformatf("write to %h", bus.addr));
            end else begin
                w = exp_w.pop_front();
                check("wr_addr", 64'(bus.addr), 64'(w.addr));
                check("wr_data", bus.wdata, w.data);
                check("wr_from_stream", 64'(fire), 64'(w.from_stream));
                obs_w.push_back(mk_wr(bus.addr, bus.wdata, fire));
                if (w.addr == 16'h0400) mm_cycle = cyc;
            end
            check("wr_out_valid", 64'(out_valid), 64'h0);
        end else if (out_valid) begin
            if (exp_r.size() == 0) begin
                fail("spurious_read", $sformatf("read of %h", bus.addr));
            end else begin
                check("rd_addr", 64'(bus.addr), 64'(exp_r[0]));
                check("rd_data", out_data, tpu_rd(salt, exp_r[0]));
                check("rd_writes_left", 64'(exp_w.size()), 64'h0);
                if (!first_rd) begin
                    first_rd = 1;
                    last_lat = cyc - mm_cycle;
                    check("matmul_to_read", 64'(last_lat), 64'(WAIT_CYCLES + 1));
                end
                if (rmode == 1 && !out_ready) begin
                    check("stall_addr", 64'(bus.addr), 64'h0318);
                    stall_left--;
                end
                if (out_ready) void'(exp_r.pop_front());
            end
            check("rd_no_stream", 64'(fire), 64'h0);
        end else begin
            check("idle_addr", 64'(bus.addr), 64'h0);
            check("idle_wdata", bus.wdata, 64'h0);
            check("idle_no_stream", 64'(fire), 64'h0);
        end
        if (done) begin
            check("done_in_job", 64'(phase), 64'h1);
            check("done_writes_left", 64'(exp_w.size()), 64'h0);
            check("done_reads_left", 64'(exp_r.size()), 64'h0);
            done_cnt++;
        end
        check("busy", 64'(busy), 64'(phase && !done));
        if (fire) wptr++;
        if (done) phase = 0;
        if (accept) begin
            phase    = 1;
            first_rd = 0;
            build_model(job_zc);
        end
    endtask

    task automatic fill_rand(int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
    endtask

    task automatic run_job(bit zc, int vm, int rm, bit st);
        bit seen = 0;
        job_zc = zc; vmode = vm; rmode = rm; stall_left = 5;
        wptr = 0; salt = $urandom; done_cnt = 0; obs_w.delete();
        start_req = 1;
        stray = 0;
        tick();
        stray = st;
        for (int n = 0; n < 600 && !seen; n++) begin
            tick();
            if (done_cnt != 0) seen = 1;
        end
        stray = 0;
        if (!seen) fail("job_timeout", "no done within 600 cycles");
        check("consumed", 64'(wptr), zc ? 64'd16 : 64'd32);
        if (rm == 1) check("stall_cycles", 64'(stall_left), 64'h0);
        repeat (3) tick();
        check("done_once", 64'(done_cnt), 64'h1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with start held high.
        rst_n = 1'b0; start = 1'b1; zero_c = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0; salt = 32'h0;
        #12;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_r_w", 64'(bus.r_w), 64'h0);
        check("rst_addr", 64'(bus.addr), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;

        // Job 1: continuous stream 0x1..0x20, pinned against literals.
        words.delete();
        for (int i = 1; i <= 32; i++) words.push_back(64'(i));
        run_job(0, 0, 0, 0);
        check("pin_nwrites", 64'(obs_w.size()), 64'd33);
        if (obs_w.size() >= 33) begin
            check("pin_w0_addr", 64'(obs_w[0].addr), 64'h0100);
            check("pin_w0_data", obs_w[0].data, 64'h1);
            check("pin_w7_addr", 64'(obs_w[7].addr), 64'h0138);
            check("pin_w8_addr", 64'(obs_w[8].addr), 64'h0200);
            check("pin_w8_data", obs_w[8].data, 64'h9);
            check("pin_w17_addr", 64'(obs_w[17].addr), 64'h0308);
            check("pin_w31_addr", 64'(obs_w[31].addr), 64'h0378);
            check("pin_w31_data", obs_w[31].data, 64'h20);
            check("pin_mm_addr", 64'(obs_w[32].addr), 64'h0400);
        end
        check("pin_latency", 64'(last_lat), 64'd25);

        // Job 2: zero-fill C; extra words on offer must stay unconsumed.
        fill_rand(24);
        run_job(1, 0, 0, 0);

        // Job 3: in_valid toggling.
        fill_rand(32);
        run_job(0, 1, 0, 0);

        // Job 4: out_ready low for 5 cycles at the fourth read.
        fill_rand(32);
        run_job(0, 0, 1, 0);

        // Reset during LOAD_B idx=4.
        fill_rand(32);
        job_zc = 0; vmode = 0; rmode = 0; wptr = 0; salt = $urandom;
        start_req = 1;
        tick();
        for (int n = 0; n < 100 && wptr < 12; n++) tick();
        check("abort_point", 64'(wptr), 64'd12);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_r_w", 64'(bus.r_w), 64'h0);
        check("abort_addr", 64'(bus.addr), 64'h0);
        check("abort_in_ready", 64'(in_ready), 64'h0);
        check("abort_out_valid", 64'(out_valid), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        phase = 0;
        exp_w.delete();
        exp_r.delete();
        fill_rand(32);
        run_job(0, 2, 2, 1);
        if (obs_w.size() > 0) check("restart_addr", 64'(obs_w[0].addr), 64'h0100);
        else fail("restart_addr", "no writes after reset");

        // Random jobs with stray start pulses while busy.
        for (int j = 0; j < 6; j++) begin
            fill_rand(32);
            run_job(1'($urandom_range(0, 1)), 2, 2, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
